// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, MIPS-style opcodes, and the fetch stage
// state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [5:0] {
        RTYPE = 6'b000000,
        J     = 6'b000010,
        JAL   = 6'b000011,
        BEQ   = 6'b000100,
        BNE   = 6'b000101,
        ADDIU = 6'b001001,
        LUI   = 6'b001111,
        LW    = 6'b100011,
        SW    = 6'b101011,
        HALT  = 6'b111111
    } opcode_t;

    typedef enum logic [1:0] {
        REQ    = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory port between fetch and imem.
// imemREN requests a read of imemaddr; the request and address stay stable
// until imem answers with ihit=1, and imemload is valid only in that cycle.
interface fetch_stage_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;

    modport master (output imemREN, output imemaddr, input ihit, input imemload);
    modport slave  (input imemREN, input imemaddr, output ihit, output imemload);

endinterface

// File: rtl/fetch_stage_pc_register.sv
// Program counter with a wrapping +4 incrementer.
// Priority: reset, then load, then increment.
module pc_register
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h00000000
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  load,
    input  logic  inc,
    input  word_t load_pc,
    output word_t pc,
    output word_t pc_plus4
);

    assign pc_plus4 = pc + PC_STEP;

    always_ff @(posedge CLK) begin
        if (RST)
            pc <= PC_INIT;
        else if (load)
            pc <= load_pc;
        else if (inc)
            pc <= pc_plus4;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: requests words from imem, presents them to IF/ID and
// buffers one word across downstream stalls; handles redirect and halt.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h00000000
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         stall,
    input  logic         redirect,
    input  word_t        redirect_pc,
    input  logic         halt,
    fetch_stage_if.master imem,
    output logic         out_valid,
    output logic         flush_out,
    output word_t        pc_inc,
    output word_t        instr,
    output opcode_t      opcode,
    output fetch_state_t state_dbg
);

    fetch_state_t state, next_state;
    word_t        pc, pc_plus4;
    word_t        hold_instr, hold_pc_inc;
    logic         pc_load, pc_inc_en, capture, clear_buf;
    logic         ren_c, valid_c, flush_c;
    word_t        instr_c, pc_inc_c;

    pc_register #(.PC_INIT(PC_INIT)) u_pc (
        .CLK      (CLK),
        .RST      (RST),
        .load     (pc_load),
        .inc      (pc_inc_en),
        .load_pc  ({redirect_pc[31:2], 2'b00}),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    always_ff @(posedge CLK) begin
        if (RST)
            state <= REQ;
        else
            state <= next_state;
    end

    // The buffered word is the one that arrived while IF/ID was stalled.
    always_ff @(posedge CLK) begin
        if (RST || clear_buf) begin
            hold_instr  <= '0;
            hold_pc_inc <= '0;
        end else if (capture) begin
            hold_instr  <= imem.imemload;
            hold_pc_inc <= pc_plus4;
        end
    end

    always_comb begin
        next_state = state;
        pc_load    = 1'b0;
        pc_inc_en  = 1'b0;
        capture    = 1'b0;
        clear_buf  = 1'b0;
        ren_c      = 1'b0;
        valid_c    = 1'b0;
        flush_c    = 1'b0;
        instr_c    = '0;
        pc_inc_c   = '0;
        case (state)
            REQ: begin
                ren_c    = 1'b1;
                instr_c  = imem.imemload;
                pc_inc_c = pc_plus4;
                if (halt) begin
                    next_state = HALTED;
                end else if (redirect) begin
                    flush_c   = 1'b1;
                    pc_load   = 1'b1;
                    clear_buf = 1'b1;
                end else if (imem.ihit) begin
                    if (stall) begin
                        capture    = 1'b1;
                        next_state = HOLD;
                    end else begin
                        valid_c   = 1'b1;
                        pc_inc_en = 1'b1;
                    end
                end
            end
            HOLD: begin
                instr_c  = hold_instr;
                pc_inc_c = hold_pc_inc;
                if (halt) begin
                    next_state = HALTED;
                end else if (redirect) begin
                    flush_c    = 1'b1;
                    pc_load    = 1'b1;
                    clear_buf  = 1'b1;
                    next_state = REQ;
                end else if (!stall) begin
                    valid_c    = 1'b1;
                    pc_inc_en  = 1'b1;
                    next_state = REQ;
                end
            end
            HALTED: begin
                next_state = HALTED;
            end
            default: begin
                next_state = REQ;
            end
        endcase
        if (RST) begin
            ren_c    = 1'b0;
            valid_c  = 1'b0;
            flush_c  = 1'b0;
            instr_c  = '0;
            pc_inc_c = '0;
        end
    end

    assign imem.imemREN  = ren_c;
    assign imem.imemaddr = pc;
    assign out_valid     = valid_c;
    assign flush_out     = flush_c;
    assign instr         = instr_c;
    assign pc_inc        = pc_inc_c;
    assign opcode        = opcode_t'(instr_c[31:26]);
    assign state_dbg     = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, halt/reset sequence, then
// randomized traffic against a queue-based reference model.
module tb_fetch_stage;
    import cpu_types_pkg::*;

    logic         CLK = 1'b0;
    logic         RST, stall, redirect, halt;
    word_t        redirect_pc;
    logic         out_valid, flush_out;
    word_t        pc_inc, instr;
    opcode_t      opcode;
    fetch_state_t state_dbg;

    int checks   = 0;
    int failures = 0;

    fetch_stage_if imem();

    fetch_stage #(.PC_INIT(32'h00000000)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imem        (imem),
        .out_valid   (out_valid),
        .flush_out   (flush_out),
        .pc_inc      (pc_inc),
        .instr       (instr),
        .opcode      (opcode),
        .state_dbg   (state_dbg)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic  rst, stl, rdr;
        word_t rpc;
        logic  hlt, hit;
        word_t load;
        logic  e_ren;
        word_t e_addr;
        logic  e_valid, e_flush;
        word_t e_instr, e_pci;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(logic rst, logic stl, logic rdr, word_t rpc, logic hlt,
                                logic hit, word_t load, logic e_ren, word_t e_addr,
                                logic e_valid, logic e_flush, word_t e_instr, word_t e_pci);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.hlt = hlt; v.hit = hit;
        v.load = load; v.e_ren = e_ren; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_flush = e_flush; v.e_instr = e_instr; v.e_pci = e_pci;
        return v;
    endfunction

    task automatic check(string name, word_t act, word_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(logic rst, logic stl, logic rdr, word_t rpc, logic hlt,
                         logic hit, word_t load);
        @(negedge CLK);
        RST = rst; stall = stl; redirect = rdr; redirect_pc = rpc; halt = hlt;
        imem.ihit = hit; imem.imemload = load;
        #1;
    endtask

    task automatic check_all(string tag, logic e_ren, word_t e_addr, logic e_valid,
                             logic e_flush, word_t e_instr, word_t e_pci);
        word_t op_act, op_exp;
        op_act = {26'd0, opcode};
        op_exp = {26'd0, e_instr[31:26]};
        check({tag, ".ren"},    {31'd0, imem.imemREN}, {31'd0, e_ren});
        check({tag, ".addr"},   imem.imemaddr, e_addr);
        check({tag, ".valid"},  {31'd0, out_valid}, {31'd0, e_valid});
        check({tag, ".flush"},  {31'd0, flush_out}, {31'd0, e_flush});
        check({tag, ".instr"},  instr, e_instr);
        check({tag, ".pc_inc"}, pc_inc, e_pci);
        check({tag, ".opcode"}, op_act, op_exp);
    endtask

    // Reference model state: PC, at most one parked word, halted flag.
    word_t m_pc;
    word_t m_held_instr[$];
    word_t m_held_pci[$];
    bit    m_halted;

    initial begin
        logic  r_rst, r_stl, r_rdr, r_hlt, r_hit;
        word_t r_rpc, r_load;
        logic  e_ren, e_valid, e_flush;
        word_t e_instr, e_pci;

        RST = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        imem.ihit = 1'b0; imem.imemload = '0;
        @(posedge CLK);

        //          rst stl rdr rpc           hlt hit load          ren addr          vld flu instr         pci
        tbl[0]  = mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0);
        tbl[1]  = mk(0, 0, 0, 32'h0,        0, 1, 32'h00000011, 1, 32'h0,        1, 0, 32'h00000011, 32'h4);
        tbl[2]  = mk(0, 0, 0, 32'h0,        0, 1, 32'h00000022, 1, 32'h4,        1, 0, 32'h00000022, 32'h8);
        tbl[3]  = mk(0, 0, 0, 32'h0,        0, 1, 32'h00000033, 1, 32'h8,        1, 0, 32'h00000033, 32'hC);
        tbl[4]  = mk(1, 0, 0, 32'h0,        0, 1, 32'h00000044, 0, 32'hC,        0, 0, 32'h0,        32'h0);
        tbl[5]  = mk(0, 1, 0, 32'h0,        0, 1, 32'h8C220004, 1, 32'h0,        0, 0, 32'h8C220004, 32'h4);
        tbl[6]  = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h8C220004, 32'h4);
        tbl[7]  = mk(0, 1, 0, 32'h0,        0, 1, 32'hDEADBEEF, 0, 32'h0,        0, 0, 32'h8C220004, 32'h4);
        tbl[8]  = mk(0, 0, 0, 32'h0,        0, 1, 32'hDEADBEEF, 0, 32'h0,        1, 0, 32'h8C220004, 32'h4);
        tbl[9]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h4,        0, 0, 32'h0,        32'h8);
        tbl[10] = mk(0, 0, 1, 32'h00000103, 0, 1, 32'h00000055, 1, 32'h4,        0, 1, 32'h00000055, 32'h8);
        tbl[11] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h100,      0, 0, 32'h0,        32'h104);
        tbl[12] = mk(0, 0, 1, 32'hFFFFFFFF, 0, 0, 32'h0,        1, 32'h100,      0, 1, 32'h0,        32'h104);
        tbl[13] = mk(0, 0, 0, 32'h0,        0, 1, 32'h00000077, 1, 32'hFFFFFFFC, 1, 0, 32'h00000077, 32'h0);
        tbl[14] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,        32'h4);
        tbl[15] = mk(0, 1, 0, 32'h0,        0, 1, 32'h00000066, 1, 32'h0,        0, 0, 32'h00000066, 32'h4);
        tbl[16] = mk(0, 1, 1, 32'h00000020, 0, 1, 32'h00000099, 0, 32'h0,        0, 1, 32'h00000066, 32'h4);
        tbl[17] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h20,       0, 0, 32'h0,        32'h24);
        tbl[18] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h20,       0, 0, 32'h0,        32'h24);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rst, tbl[i].stl, tbl[i].rdr, tbl[i].rpc, tbl[i].hlt, tbl[i].hit, tbl[i].load);
            check_all($sformatf("vec%0d", i), tbl[i].e_ren, tbl[i].e_addr, tbl[i].e_valid,
                      tbl[i].e_flush, tbl[i].e_instr, tbl[i].e_pci);
        end

        // Halt beats a simultaneous redirect; PC stays at 0x20.
        drive(0, 0, 1, 32'h00000200, 1, 1, 32'h12345678);
        check_all("halt_cycle", 1, 32'h20, 0, 0, 32'h12345678, 32'h24);
        for (int i = 0; i < 10; i++) begin
            drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom);
            check($sformatf("halted%0d.state", i), {30'd0, state_dbg}, {30'd0, HALTED});
            check($sformatf("halted%0d.ren", i),   {31'd0, imem.imemREN}, 32'd0);
            check($sformatf("halted%0d.valid", i), {31'd0, out_valid}, 32'd0);
            check($sformatf("halted%0d.flush", i), {31'd0, flush_out}, 32'd0);
            check($sformatf("halted%0d.addr", i),  imem.imemaddr, 32'h20);
        end
        drive(1, 1, 1, 32'h00000300, 1, 1, 32'hFFFFFFFF);
        check_all("halt_rst", 0, 32'h20, 0, 0, 32'h0, 32'h0);
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        check_all("after_rst", 1, 32'h0, 0, 0, 32'h0, 32'h4);

        m_pc = 32'h0;
        m_halted = 1'b0;
        m_held_instr.delete();
        m_held_pci.delete();

        for (int n = 0; n < 3000; n++) begin
            r_rst  = ($urandom_range(0, 39) == 0);
            r_hlt  = ($urandom_range(0, 63) == 0);
            r_rdr  = ($urandom_range(0, 7) == 0);
            r_stl  = ($urandom_range(0, 2) == 0);
            r_hit  = ($urandom_range(0, 3) != 0);
            r_rpc  = $urandom;
            r_load = $urandom;
            if ($urandom_range(0, 15) == 0) r_rpc = 32'hFFFFFFFC;
            drive(r_rst, r_stl, r_rdr, r_rpc, r_hlt, r_hit, r_load);

            e_ren = 0; e_valid = 0; e_flush = 0; e_instr = '0; e_pci = '0;
            if (!r_rst && !m_halted) begin
                if (m_held_instr.size() != 0) begin
                    e_instr = m_held_instr[0];
                    e_pci   = m_held_pci[0];
                    e_valid = !r_stl && !r_rdr && !r_hlt;
                end else begin
                    e_ren   = 1;
                    e_instr = r_load;
                    e_pci   = m_pc + 32'd4;
                    e_valid = r_hit && !r_stl && !r_rdr && !r_hlt;
                end
                e_flush = r_rdr && !r_hlt;
            end

            if (m_halted && !r_rst) begin
                check("rnd.ren",   {31'd0, imem.imemREN}, 32'd0);
                check("rnd.valid", {31'd0, out_valid}, 32'd0);
                check("rnd.flush", {31'd0, flush_out}, 32'd0);
                check("rnd.addr",  imem.imemaddr, m_pc);
            end else begin
                check_all($sformatf("rnd%0d", n), e_ren, m_pc, e_valid, e_flush, e_instr, e_pci);
            end

            if (r_rst) begin
                m_pc = 32'h0;
                m_halted = 1'b0;
                m_held_instr.delete();
                m_held_pci.delete();
            end else if (m_halted) begin
                m_halted = 1'b1;
            end else if (r_hlt) begin
                m_halted = 1'b1;
            end else if (r_rdr) begin
                m_pc = r_rpc & 32'hFFFFFFFC;
                m_held_instr.delete();
                m_held_pci.delete();
            end else if (m_held_instr.size() != 0) begin
                if (!r_stl) begin
                    m_pc = m_pc + 32'd4;
                    m_held_instr.delete();
                    m_held_pci.delete();
                end
            end else if (r_hit) begin
                if (r_stl) begin
                    m_held_instr.push_back(r_load);
                    m_held_pci.push_back(m_pc + 32'd4);
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
